// File: rtl/adder_accum_serial_unsigned_if.sv
//------------------------------------------------------------------------------
// adder_accum_serial_unsigned_if
//
// Purpose : Groups the operand stream, the sum stream, the flush control and
//           the group-progress status of adder_accum_serial_unsigned into one
//           bundle.
//
// Signals :
//   clear     - synchronous flush request (driven by the producer side)
//   in_valid  - operand beat valid
//   in_ready  - accumulator accepts the operand this cycle
//   in_data   - unsigned operand, width bits
//   out_valid - S holds a completed group sum
//   out_ready - consumer takes S this cycle
//   S         - unsigned group sum, width+2 bits, indexed [width+2:1]
//   op_cnt    - operands accepted so far in the current group
//
// Modports:
//   master - environment side (drives operands, flush and out_ready)
//   slave  - accumulator side
//------------------------------------------------------------------------------
interface adder_accum_serial_unsigned_if #(
  parameter int width = 17
);
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [width-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [width+2:1]   S;
  logic [1:0]         op_cnt;

  modport master (
    output clear,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  S,
    input  op_cnt
  );

  modport slave (
    input  clear,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output S,
    output op_cnt
  );
endinterface

// File: rtl/adder_accum_serial_unsigned.sv
//------------------------------------------------------------------------------
// adder_accum_serial_unsigned
//
// Purpose : Serial replacement for a 4-operand unsigned adder tree. Operands
//           arrive one per beat on a valid/ready stream; every NUM_OPS accepted
//           operands are summed and the result is offered on a valid/ready
//           output stream. Sums are width+2 bits wide, so a group of up to
//           four operands can never overflow.
//
// Parameters:
//   width   - operand width in bits
//   NUM_OPS - operands per group, legal range 2..4
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - adder_accum_serial_unsigned_if.slave
//            (clear, in_valid/in_ready/in_data, out_valid/out_ready/S, op_cnt)
//
// Build option:
//   ACCUM_EARLY_ACCEPT_EN - when defined, an operand may be accepted in the
//   same cycle the pending sum is taken (in_ready follows out_ready while a
//   result is held). This creates a combinational out_ready -> in_ready path
//   that has to be accounted for at integration. Back-to-back groups then
//   need NUM_OPS cycles instead of NUM_OPS+1.
//------------------------------------------------------------------------------
module adder_accum_serial_unsigned #(
  parameter int width   = 17,
  parameter int NUM_OPS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  adder_accum_serial_unsigned_if.slave   bus
);

  localparam int          SW       = width + 2;
  localparam logic [1:0]  LAST_CNT = 2'(NUM_OPS - 1);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Zero-extend an operand to the accumulator width.
  function automatic logic [SW-1:0] zext(input logic [width-1:0] d);
    return {2'b00, d};
  endfunction

  state_t            r_state;
  logic [SW-1:0]     r_acc;
  logic [1:0]        r_op_cnt;
  logic [width+2:1]  r_s;
  logic              r_out_valid;

  state_t            w_state_nxt;
  logic [SW-1:0]     w_acc_nxt;
  logic [1:0]        w_op_cnt_nxt;
  logic [width+2:1]  w_s_nxt;
  logic              w_out_valid_nxt;

  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [SW-1:0]     w_operand;

  assign w_operand  = zext(bus.in_data);
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;

  // Operand-side ready: open while accumulating; optionally also while the
  // held sum is being taken in this very cycle.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_ACC: begin
        w_in_ready = 1'b1;
      end
      ST_HOLD: begin
`ifdef ACCUM_EARLY_ACCEPT_EN
        w_in_ready = bus.out_ready;
`else
        w_in_ready = 1'b0;
`endif
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update; clear overrides every handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_op_cnt_nxt    = r_op_cnt;
    w_s_nxt         = r_s;
    w_out_valid_nxt = r_out_valid;

    if (bus.clear) begin
      // S deliberately keeps its last value; only its valid flag drops.
      w_state_nxt     = ST_ACC;
      w_acc_nxt       = {SW{1'b0}};
      w_op_cnt_nxt    = 2'd0;
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_in_fire) begin
            if (r_op_cnt == LAST_CNT) begin
              w_s_nxt         = r_acc + w_operand;
              w_acc_nxt       = {SW{1'b0}};
              w_op_cnt_nxt    = 2'd0;
              w_out_valid_nxt = 1'b1;
              w_state_nxt     = ST_HOLD;
            end else begin
              w_acc_nxt    = r_acc + w_operand;
              w_op_cnt_nxt = r_op_cnt + 2'd1;
            end
          end else begin
            w_acc_nxt    = r_acc;
            w_op_cnt_nxt = r_op_cnt;
          end
        end
        ST_HOLD: begin
          if (w_out_fire) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = ST_ACC;
            // An operand taken during the handoff opens the next group;
            // in the base build w_in_fire is never set in this state.
            if (w_in_fire) begin
              w_acc_nxt    = w_operand;
              w_op_cnt_nxt = 2'd1;
            end else begin
              w_acc_nxt    = r_acc;
              w_op_cnt_nxt = r_op_cnt;
            end
          end else begin
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = ST_HOLD;
          end
        end
        default: begin
          w_state_nxt     = ST_ACC;
          w_acc_nxt       = {SW{1'b0}};
          w_op_cnt_nxt    = 2'd0;
          w_out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_acc       <= {SW{1'b0}};
      r_op_cnt    <= 2'd0;
      r_s         <= {SW{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_op_cnt    <= w_op_cnt_nxt;
      r_s         <= w_s_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.S         = r_s;
  assign bus.op_cnt    = r_op_cnt;

endmodule
